svi_rr_arbiter: RTL and testbench
=================================

Name: svi_rr_arbiter

Overview:
- Round-robin arbiter sharing one registered downstream consumer among SIZE requesters. Each requester is one element of an I interface array and presents its x/y scalars.
- Sits in top-level wrappers between the per-element I array / M instances and a single output stage, replacing the broadcast-to-all sampling pattern.
- Captures the winning element's x/y pair and holds it under a valid/ready handshake.
- Grants rotate fairly to the requester after the last winner.

Parameters:
- SIZE, 8, number of requesters (interface array elements); legal range 1..32.
- IDX_W, (SIZE>1 ? $clog2(SIZE) : 1), width of the grant index.
- CNT_W, 16, width of the transfer counter.

Ports:
- i_clk  input  1  clock, all state on its rising edge.
- i_arst_n  input  1  asynchronous active-low reset.
- i_req  input  SIZE  per-element request, bit k = element k.
- i_x  input  SIZE  per-element x scalar (u_I[k].x).
- i_y  input  SIZE  per-element y scalar (u_I[k].y).
- i_ready  input  1  downstream accepts the current output.
- o_valid  output  1  output pair is valid.
- o_a  output  1  captured x of the granted element.
- o_b  output  1  captured y of the granted element.
- o_grant  output  SIZE  one-hot grant; all zero when not valid.
- o_grant_idx  output  IDX_W  binary index of the granted element.
- o_xfer_cnt  output  CNT_W  count of completed handshakes, wraps.

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_arst_n is asynchronous, active-low.
- Reset values:
  - o_valid=0, o_a=0, o_b=0, o_grant=0, o_grant_idx=0, o_xfer_cnt=0.
  - Priority pointer ptr=0; state IDLE.
- Reset asserted mid-transfer clears all state immediately, with no handshake completion and no count increment.
- FSM states: IDLE and BUSY.
- Winner selection (combinational):
  - Winner = first k with i_req[k]=1, scanning ptr, ptr+1, ..., SIZE-1, 0, ..., ptr-1 (modulo SIZE).
  - No request means no winner.
- IDLE:
  - On a clock edge with any i_req set: register o_grant=onehot(winner), o_grant_idx=winner, o_a=i_x[winner], o_b=i_y[winner], o_valid=1; go to BUSY.
  - Latency is 1 cycle from request to o_valid.
- BUSY, i_ready=0:
  - All outputs hold stable.
  - Later changes on i_req, i_x or i_y are ignored. Data was captured at grant, and withdrawing the request does not cancel the grant.
- BUSY, i_ready=1 (handshake completes this edge):
  - o_xfer_cnt increments by 1, wrapping at 2^CNT_W.
  - ptr <= (o_grant_idx+1) mod SIZE.
  - The next winner is computed from the new ptr against the current i_req; the just-served element is included at lowest priority.
  - If a winner exists: load it the same edge (back-to-back, o_valid stays 1) and stay in BUSY.
  - Otherwise: o_valid=0, o_grant=0, go to IDLE.
- Outputs while IDLE: o_a, o_b and o_grant_idx keep their last values; only o_valid and o_grant clear.
- i_ready while IDLE has no effect.
- Fairness: with all requests held, grants cycle 0,1,...,SIZE-1,0. No requester waits more than SIZE handshakes.
- SIZE=1: ptr is constant 0; a held request is granted every cycle while i_ready=1.
- Throughput: with requests continuously pending and i_ready held high, one transfer per cycle.

Test Plan:
- Reset then i_req=8'b0000_0100, i_x[2]=1, i_y[2]=0, i_ready=1 -> next edge o_valid=1, o_grant=8'h04, o_grant_idx=2, o_a=1, o_b=0. Following edge o_valid=0, o_xfer_cnt=1, ptr=3.
- i_req=8'hFF held, i_ready=1 for 10 cycles -> o_grant_idx sequence 0,1,...,7,0,1 with o_valid constant 1; o_xfer_cnt=10 at end.
- Grant element 5, i_ready=0 for 4 cycles while i_x[5] toggles and i_req[5] drops -> o_a/o_grant/o_grant_idx unchanged. On i_ready=1, count +1; o_valid drops if no other request is pending.
- ptr=3 after serving 2, then i_req=8'b0000_0101 -> grant 0 (wrap), then 2.
- Assert i_arst_n=0 asynchronously mid-cycle while BUSY -> o_valid, o_grant and o_xfer_cnt are 0 before the next edge. After release with i_req=8'h80, grant idx 7 with ptr starting from 0.
- Preload o_xfer_cnt near wrap (CNT_W=4, 16 handshakes) -> o_xfer_cnt reads 0 after the 16th transfer.

Source files
------------

// File: rtl/svi_rr_arbiter.sv
// Round-robin arbiter: picks one of SIZE requesters, captures its x/y pair
// and holds it under a valid/ready handshake toward a single consumer.
//
// state | meaning
// IDLE  | no captured pair; o_valid=0, waiting for any request
// BUSY  | pair captured and held until the consumer asserts i_ready
module svi_rr_arbiter #(
    parameter int SIZE  = 8,
    parameter int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_arst_n,
    input  logic [SIZE-1:0]  i_req,
    input  logic [SIZE-1:0]  i_x,
    input  logic [SIZE-1:0]  i_y,
    input  logic             i_ready,
    output logic             o_valid,
    output logic             o_a,
    output logic             o_b,
    output logic [SIZE-1:0]  o_grant,
    output logic [IDX_W-1:0] o_grant_idx,
    output logic [CNT_W-1:0] o_xfer_cnt
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_next;
    logic [IDX_W-1:0] scan_base;
    logic [IDX_W-1:0] win_idx;
    logic             win_found;
    logic             load, clear, xfer;
    int               np;

    // Scan base..SIZE-1 then 0..base-1; first requester found wins.
    function automatic logic [IDX_W:0] pick(input logic [SIZE-1:0] req, input int base);
        logic             found;
        logic [IDX_W-1:0] idx;
        int               k;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < SIZE; i++) begin
            k = base + i;
            if (k >= SIZE) k = k - SIZE;
            if (!found && req[k]) begin
                found = 1'b1;
                idx   = IDX_W'(k);
            end
        end
        return {found, idx};
    endfunction

    // On a completing handshake the scan starts just past the served element,
    // so a back-to-back grant already sees the rotated priority.
    always_comb begin
        np = int'(o_grant_idx) + 1;
        if (np >= SIZE) np = 0;
        ptr_next  = IDX_W'(np);
        scan_base = (state_q == BUSY) ? ptr_next : ptr_q;
        {win_found, win_idx} = pick(i_req, int'(scan_base));
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) state_q <= IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        clear   = 1'b0;
        xfer    = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    load    = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (i_ready) begin
                    xfer = 1'b1;
                    if (win_found) begin
                        load = 1'b1;
                    end else begin
                        clear   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            o_valid     <= 1'b0;
            o_a         <= 1'b0;
            o_b         <= 1'b0;
            o_grant     <= '0;
            o_grant_idx <= '0;
            o_xfer_cnt  <= '0;
            ptr_q       <= '0;
        end else begin
            if (load) begin
                o_valid     <= 1'b1;
                o_grant     <= SIZE'(1) << win_idx;
                o_grant_idx <= win_idx;
                o_a         <= i_x[win_idx];
                o_b         <= i_y[win_idx];
            end else if (clear) begin
                o_valid <= 1'b0;
                o_grant <= '0;
            end
            if (xfer) begin
                o_xfer_cnt <= o_xfer_cnt + 1'b1;
                ptr_q      <= ptr_next;
            end
        end
    end

endmodule

// File: tb/tb_svi_rr_arbiter.sv
// Directed bench for svi_rr_arbiter: grant rotation, hold under backpressure,
// asynchronous reset and transfer-counter wrap.
module tb_svi_rr_arbiter;

    logic       i_clk = 1'b0;
    logic       i_arst_n = 1'b0;
    logic [7:0] i_req = '0, i_x = '0, i_y = '0;
    logic       i_ready = 1'b0;
    logic       o_valid, o_a, o_b;
    logic [7:0] o_grant;
    logic [2:0] o_grant_idx;
    logic [15:0] o_xfer_cnt;

    logic [7:0] w_req = '0;
    logic       w_ready = 1'b0;
    logic       w_valid, w_a, w_b;
    logic [7:0] w_grant;
    logic [2:0] w_grant_idx;
    logic [3:0] w_xfer_cnt;

    int n_vec = 0;
    int n_err = 0;
    int exp_cnt = 0;

    always #5 i_clk = ~i_clk;

    svi_rr_arbiter #(.SIZE(8), .CNT_W(16)) dut (
        .i_clk(i_clk), .i_arst_n(i_arst_n), .i_req(i_req), .i_x(i_x), .i_y(i_y),
        .i_ready(i_ready), .o_valid(o_valid), .o_a(o_a), .o_b(o_b),
        .o_grant(o_grant), .o_grant_idx(o_grant_idx), .o_xfer_cnt(o_xfer_cnt)
    );

    svi_rr_arbiter #(.SIZE(8), .CNT_W(4)) dut_w (
        .i_clk(i_clk), .i_arst_n(i_arst_n), .i_req(w_req), .i_x(8'h00), .i_y(8'h00),
        .i_ready(w_ready), .o_valid(w_valid), .o_a(w_a), .o_b(w_b),
        .o_grant(w_grant), .o_grant_idx(w_grant_idx), .o_xfer_cnt(w_xfer_cnt)
    );

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        #2;
        i_arst_n = 1'b0;
        i_req = '0; i_x = '0; i_y = '0; i_ready = 1'b0;
        exp_cnt = 0;
        #3;
        i_arst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        i_arst_n = 1'b0;
        #3;
        n_vec++;
        if ({o_valid, o_a, o_b, o_grant, o_grant_idx, o_xfer_cnt} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got v=%0b a=%0b b=%0b g=%h idx=%0d cnt=%0d, want all 0",
                     o_valid, o_a, o_b, o_grant, o_grant_idx, o_xfer_cnt);
        end
        #4;
        i_arst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        i_req = 8'b0000_0100; i_x = 8'h04; i_y = 8'h00; i_ready = 1'b1;
        tick();
        n_vec++;
        if ({o_valid, o_grant, o_grant_idx, o_a, o_b} !== {1'b1, 8'h04, 3'd2, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL single_grant: got v=%0b g=%h idx=%0d a=%0b b=%0b, want v=1 g=04 idx=2 a=1 b=0",
                     o_valid, o_grant, o_grant_idx, o_a, o_b);
        end
        i_req = '0;
        tick();
        exp_cnt = 1;
        n_vec++;
        if ({o_valid, o_grant, o_grant_idx, o_a, o_xfer_cnt} !== {1'b0, 8'h00, 3'd2, 1'b1, 16'd1}) begin
            n_err++;
            $display("FAIL single_release: got v=%0b g=%h idx=%0d a=%0b cnt=%0d, want v=0 g=00 idx=2 a=1 cnt=1",
                     o_valid, o_grant, o_grant_idx, o_a, o_xfer_cnt);
        end
    endtask

    // ptr is 3 after serving 2: request 0 and 2 -> 0 (wrap), then 2, then 0.
    task automatic test_wrap_ptr();
        logic [2:0] exp_idx [3];
        exp_idx[0] = 3'd0; exp_idx[1] = 3'd2; exp_idx[2] = 3'd0;
        i_req = 8'b0000_0101; i_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i > 0) exp_cnt++;
            n_vec++;
            if (o_valid !== 1'b1 || o_grant_idx !== exp_idx[i] || o_xfer_cnt !== 16'(exp_cnt)) begin
                n_err++;
                $display("FAIL wrap_ptr[%0d]: got v=%0b idx=%0d cnt=%0d, want v=1 idx=%0d cnt=%0d",
                         i, o_valid, o_grant_idx, o_xfer_cnt, exp_idx[i], exp_cnt);
            end
        end
        i_req = '0;
        tick();
        exp_cnt++;
        n_vec++;
        if (o_valid !== 1'b0 || o_xfer_cnt !== 16'(exp_cnt)) begin
            n_err++;
            $display("FAIL wrap_drain: got v=%0b cnt=%0d, want v=0 cnt=%0d", o_valid, o_xfer_cnt, exp_cnt);
        end
    endtask

    task automatic test_fairness();
        do_reset();
        i_req = 8'hFF; i_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_vec++;
            if (o_valid !== 1'b1 || o_grant_idx !== 3'(i % 8) || o_grant !== (8'h01 << (i % 8))) begin
                n_err++;
                $display("FAIL fair_seq[%0d]: got v=%0b idx=%0d g=%h, want v=1 idx=%0d", i,
                         o_valid, o_grant_idx, o_grant, i % 8);
            end
        end
        i_req = '0;
        tick();
        exp_cnt = 10;
        n_vec++;
        if (o_xfer_cnt !== 16'd10 || o_valid !== 1'b0) begin
            n_err++;
            $display("FAIL fair_count: got cnt=%0d v=%0b, want cnt=10 v=0", o_xfer_cnt, o_valid);
        end
    endtask

    task automatic test_hold();
        i_req = 8'h20; i_x = 8'h20; i_y = 8'h20; i_ready = 1'b0;
        tick();
        n_vec++;
        if ({o_valid, o_grant, o_grant_idx, o_a, o_b} !== {1'b1, 8'h20, 3'd5, 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL hold_grant: got v=%0b g=%h idx=%0d a=%0b b=%0b, want v=1 g=20 idx=5 a=1 b=1",
                     o_valid, o_grant, o_grant_idx, o_a, o_b);
        end
        for (int i = 0; i < 4; i++) begin
            i_x = ~i_x; i_y = ~i_y;
            if (i == 1) i_req = 8'h00;
            tick();
            n_vec++;
            if ({o_valid, o_grant, o_grant_idx, o_a, o_b, o_xfer_cnt} !==
                {1'b1, 8'h20, 3'd5, 1'b1, 1'b1, 16'(exp_cnt)}) begin
                n_err++;
                $display("FAIL hold_stable[%0d]: got v=%0b g=%h idx=%0d a=%0b b=%0b cnt=%0d, want v=1 g=20 idx=5 a=1 b=1 cnt=%0d",
                         i, o_valid, o_grant, o_grant_idx, o_a, o_b, o_xfer_cnt, exp_cnt);
            end
        end
        i_ready = 1'b1;
        tick();
        exp_cnt++;
        n_vec++;
        if ({o_valid, o_grant, o_grant_idx, o_a, o_xfer_cnt} !== {1'b0, 8'h00, 3'd5, 1'b1, 16'(exp_cnt)}) begin
            n_err++;
            $display("FAIL hold_release: got v=%0b g=%h idx=%0d a=%0b cnt=%0d, want v=0 g=00 idx=5 a=1 cnt=%0d",
                     o_valid, o_grant, o_grant_idx, o_a, o_xfer_cnt, exp_cnt);
        end
    endtask

    task automatic test_async_reset();
        i_req = 8'h20; i_ready = 1'b0;
        tick();
        #2;
        i_arst_n = 1'b0;
        #1;
        n_vec++;
        if (o_valid !== 1'b0 || o_grant !== 8'h00 || o_xfer_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL async_reset: got v=%0b g=%h cnt=%0d, want v=0 g=00 cnt=0",
                     o_valid, o_grant, o_xfer_cnt);
        end
        i_req = 8'h81;
        #1;
        i_arst_n = 1'b1;
        exp_cnt = 0;
        tick();
        n_vec++;
        if (o_valid !== 1'b1 || o_grant_idx !== 3'd0) begin
            n_err++;
            $display("FAIL post_reset_ptr: got v=%0b idx=%0d, want v=1 idx=0", o_valid, o_grant_idx);
        end
        i_req = 8'h80; i_ready = 1'b1;
        tick();
        n_vec++;
        if (o_valid !== 1'b1 || o_grant_idx !== 3'd7 || o_grant !== 8'h80 || o_xfer_cnt !== 16'd1) begin
            n_err++;
            $display("FAIL post_reset_idx7: got v=%0b idx=%0d g=%h cnt=%0d, want v=1 idx=7 g=80 cnt=1",
                     o_valid, o_grant_idx, o_grant, o_xfer_cnt);
        end
        i_req = '0; i_ready = 1'b0;
    endtask

    task automatic test_cnt_wrap();
        w_req = 8'h01; w_ready = 1'b1;
        tick();
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i == 15 || i == 16) begin
                n_vec++;
                if (w_xfer_cnt !== 4'(i) || w_valid !== 1'b1) begin
                    n_err++;
                    $display("FAIL cnt_wrap[%0d]: got cnt=%0d v=%0b, want cnt=%0d v=1",
                             i, w_xfer_cnt, w_valid, i % 16);
                end
            end
        end
        w_req = '0;
        tick();
        n_vec++;
        if (w_xfer_cnt !== 4'd1 || w_valid !== 1'b0) begin
            n_err++;
            $display("FAIL cnt_wrap_drain: got cnt=%0d v=%0b, want cnt=1 v=0", w_xfer_cnt, w_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap_ptr();
        test_fairness();
        test_hold();
        test_async_reset();
        test_cnt_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
